// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared state encoding and default widths for count_enable_ctrl
//
// Contents:
//   DEF_DIV_W  default prescaler divide-value width
//   DEF_LEN_W  default burst-length / pulse-counter width
//   state_t    FSM state type with ST_IDLE, ST_RUN, ST_DONE encodings
package count_ctrl_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_LEN_W = 5;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - loadable down-counter with terminal-count tick
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset, clears the count
//   load        load load_val into the count (wins over run)
//   load_val    value loaded on load
//   run         count down; on terminal count reload from reload_val
//   reload_val  period-minus-one used on every reload
//   tick        high while running and the count sits at zero
module tick_prescaler
  import count_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run) begin
      if (count == '0) begin
        count <= reload_val;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign tick = run && (count == '0);

endmodule

// File: rtl/count_enable_ctrl.sv
// rtl/count_enable_ctrl.sv - burst controller producing periodic enable pulses for a counter
//
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-high reset
//   start   begin a burst (accepted only in IDLE with stop low)
//   stop    abort a burst; blocks start in IDLE
//   div     enable period minus one, captured on accepted start
//   len     enable pulses per burst, 0 = run until stop; captured on accepted start
//   enable  registered one-cycle enable pulse
//   busy    registered, high while in RUN
//   done    registered one-cycle pulse while in DONE
//   pulses  registered count of enables issued in the current burst
module count_enable_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] len,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pulses
);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             fire;
  logic             tick;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_val   (div),
    .run        (state == ST_RUN),
    .reload_val (div_q),
    .tick       (tick)
  );

  // In RUN, stop and burst completion take priority over a due tick so
  // that no enable escapes on the edge that leaves RUN.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_RUN;
          accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_DONE;
        end else if ((len_q != '0) && (pulses == len_q)) begin
          state_nxt = ST_DONE;
        end else if (tick) begin
          fire = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pulses <= '0;
      div_q  <= '0;
      len_q  <= '0;
    end else begin
      state  <= state_nxt;
      enable <= fire;
      busy   <= (state_nxt == ST_RUN);
      done   <= (state_nxt == ST_DONE);
      if (accept) begin
        div_q  <= div;
        len_q  <= len;
        pulses <= '0;
      end else if (fire) begin
        // Wraps naturally when len is 0 (continuous mode).
        pulses <= pulses + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_enable_ctrl.sv
// tb/tb_count_enable_ctrl.sv - randomized and directed bench for count_enable_ctrl
module tb_count_enable_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = '0;
  logic [4:0] len = '0;
  logic       enable;
  logic       busy;
  logic       done;
  logic [4:0] pulses;
  logic [3:0] cnt4;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_mode = 0;     // 0 idle, 1 run, 2 done
  int m_t = 0;        // edges since the accepted start
  int m_div = 0;
  int m_len = 0;
  int m_pulses = 0;
  int m_en = 0;
  int m_enables = 0;  // total enables since last reset, for the chained counter

  always #5 clk = ~clk;

  count_enable_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .div    (div),
    .len    (len),
    .enable (enable),
    .busy   (busy),
    .done   (done),
    .pulses (pulses)
  );

  // downstream 4-bit counter chained to enable
  always_ff @(posedge clk) begin
    if (reset) cnt4 <= '0;
    else if (enable) cnt4 <= cnt4 + 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model one rising edge from the inputs currently applied.
  task automatic model_edge();
    int en_before;
    en_before = m_en;
    if (en_before != 0) m_enables++;
    m_en = 0;
    if (reset) begin
      m_mode = 0; m_t = 0; m_div = 0; m_len = 0; m_pulses = 0; m_enables = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start && !stop) begin
        m_mode = 1; m_t = 0; m_div = int'(div); m_len = int'(len); m_pulses = 0;
      end
    end else begin
      m_t++;
      if (stop) m_mode = 2;
      else if (m_len != 0 && m_pulses == m_len) m_mode = 2;
      else if (m_t % (m_div + 1) == 0) begin
        m_en = 1;
        m_pulses = (m_pulses + 1) % 32;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p,
                      input logic [7:0] d, input logic [4:0] l);
    reset = r; start = s; stop = p; div = d; len = l;
    @(posedge clk);
    model_edge();
    #1;
    check("enable", int'(enable), m_en);
    check("busy",   int'(busy),   (m_mode == 1) ? 1 : 0);
    check("done",   int'(done),   (m_mode == 2) ? 1 : 0);
    check("pulses", int'(pulses), m_pulses);
    check("cnt4",   int'(cnt4),   m_enables % 16);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
  endtask

  initial begin
    int guard;
    // reset state
    step(1'b1, 1'b1, 1'b0, 8'd5, 5'd5);
    step(1'b1, 1'b0, 1'b1, 8'd5, 5'd5);

    // div=0 len=3
    step(1'b0, 1'b1, 1'b0, 8'd0, 5'd3);
    idle(6);
    check("r028_pulses_held", int'(pulses), 3);

    // div=2 len=2
    step(1'b0, 1'b1, 1'b0, 8'd2, 5'd2);
    idle(9);

    // div=1 len=0, stop at E9
    step(1'b0, 1'b1, 1'b0, 8'd1, 5'd0);
    idle(8);
    step(1'b0, 1'b0, 1'b1, 8'd0, 5'd0);
    check("r030_done", int'(done), 1);
    check("r030_pulses", int'(pulses), 4);
    idle(3);

    // start+stop together in IDLE
    step(1'b0, 1'b1, 1'b1, 8'd0, 5'd3);
    check("r031_idle_busy", int'(busy), 0);
    idle(2);
    // start pulses and div/len changes during RUN are ignored
    step(1'b0, 1'b1, 1'b0, 8'd2, 5'd2);
    step(1'b0, 1'b1, 1'b0, 8'd0, 5'd7);
    step(1'b0, 1'b1, 1'b0, 8'd9, 5'd1);
    idle(8);

    // reset at E2 of div=0 len=5, then div=0 len=3 again
    step(1'b0, 1'b1, 1'b0, 8'd0, 5'd5);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 8'd0, 5'd0);
    check("r032_pulses_cleared", int'(pulses), 0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 8'd0, 5'd3);
    idle(6);

    // chained counter: div=0 len=16 from count 0
    step(1'b1, 1'b0, 1'b0, 8'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 5'd16);
    guard = 0;
    while (!done && guard < 40) begin
      idle(1);
      guard++;
    end
    check("r033_done_seen", int'(done), 1);
    check("r033_cnt_wrapped", int'(cnt4), 0);
    check("r033_pulses", int'(pulses), 16);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, p;
      logic [7:0] d;
      logic [4:0] l;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 29) == 0);
      d = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      l = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      step(r, s, p, d, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
